// File: rtl/int_ctrl.sv
// Interrupt priority/nesting controller: fixed-priority arbitration over the latched
// pending vector, in-service tracking, redirect request and clear strobe back to ir.
//
// state  | meaning
// S_IDLE | no request outstanding; wait for an eligible line
// S_REQ  | int_req high, re-arbitrating each cycle until take or loss of eligibility
// S_ACK  | one-cycle clr pulse so ir can drop the serviced bit
module int_ctrl #(
    parameter int              N_IRQ      = 3,
    parameter int              VEC_W      = 32,
    parameter logic [VEC_W-1:0] VEC_BASE   = 32'h0000_3000,
    parameter logic [VEC_W-1:0] VEC_STRIDE = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] ir,
    input  logic             ie,
    input  logic             take,
    input  logic             eret,
    output logic             int_req,
    output logic [1:0]       int_id,
    output logic [VEC_W-1:0] int_vec,
    output logic             clr,
    output logic [N_IRQ-1:0] clr_int,
    output logic [N_IRQ-1:0] isr,
    output logic [1:0]       nest_depth
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [1:0]         cand, cur_pri, id_d;
    logic               cur_valid, eligible, accept;
    logic [N_IRQ-1:0]   id_onehot, isr_d, clr_int_d;
    logic               req_d, clr_d;

    // Ascending scans: the last set bit seen is the highest index.
    always_comb begin
        cand      = '0;
        cur_pri   = '0;
        cur_valid = 1'b0;
        id_onehot = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (ir[i])  cand = 2'(i);
            if (isr[i]) begin
                cur_pri   = 2'(i);
                cur_valid = 1'b1;
            end
            if (int_id == 2'(i)) id_onehot[i] = 1'b1;
        end
    end

    assign eligible = ie && (ir != '0) && (!cur_valid || (cand > cur_pri));
    assign accept   = (state == S_REQ) && take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            int_req <= 1'b0;
            int_id  <= '0;
            clr     <= 1'b0;
            clr_int <= '0;
            isr     <= '0;
        end else begin
            state   <= state_d;
            int_req <= req_d;
            int_id  <= id_d;
            clr     <= clr_d;
            clr_int <= clr_int_d;
            isr     <= isr_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (eligible) state_d = S_REQ;
            S_REQ: begin
                if (take)           state_d = S_ACK;
                else if (!eligible) state_d = S_IDLE;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        id_d = int_id;
        if (eligible && ((state == S_IDLE) || ((state == S_REQ) && !take)))
            id_d = cand;

        // eret retires the current level before a same-cycle take adds the new one.
        isr_d = isr;
        for (int i = 0; i < N_IRQ; i++) begin
            if (eret && cur_valid && (cur_pri == 2'(i))) isr_d[i] = 1'b0;
        end
        if (accept) isr_d = isr_d | id_onehot;

        req_d     = (state_d == S_REQ);
        clr_d     = (state_d == S_ACK);
        clr_int_d = accept ? id_onehot : '0;
    end

    always_comb begin
        nest_depth = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            nest_depth = nest_depth + {1'b0, isr[i]};
        end
    end

    assign int_vec = VEC_BASE + VEC_W'(int_id) * VEC_STRIDE;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: a vector table for the main flows plus hand
// sequences for de-assertion, upgrade, eret/take collision and reset in S_ACK.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ir;
    logic        ie, take, eret;
    logic        int_req, clr;
    logic [1:0]  int_id, nest_depth;
    logic [31:0] int_vec;
    logic [2:0]  clr_int, isr;

    int checks   = 0;
    int failures = 0;

    int_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir         (ir),
        .ie         (ie),
        .take       (take),
        .eret       (eret),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_vec    (int_vec),
        .clr        (clr),
        .clr_int    (clr_int),
        .isr        (isr),
        .nest_depth (nest_depth)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ir;
        logic       ie;
        logic       take;
        logic       eret;
        logic       e_req;
        logic [1:0] e_id;
        logic       e_clr;
        logic [2:0] e_clri;
        logic [2:0] e_isr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [2:0] i_ir, input logic i_take, input logic i_eret,
                                input logic x_req, input logic [1:0] x_id, input logic x_clr,
                                input logic [2:0] x_clri, input logic [2:0] x_isr);
        vec_t v;
        v.ir = i_ir; v.ie = 1'b1; v.take = i_take; v.eret = i_eret;
        v.e_req = x_req; v.e_id = x_id; v.e_clr = x_clr; v.e_clri = x_clri; v.e_isr = x_isr;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [1:0] e_id,
                           input logic e_clr, input logic [2:0] e_clri, input logic [2:0] e_isr);
        logic [31:0] ev;
        ev = 32'h3000 + 32'(e_id) * 32'h100;
        chk({tag, ".int_req"}, 32'(int_req), 32'(e_req));
        chk({tag, ".int_id"}, 32'(int_id), 32'(e_id));
        chk({tag, ".int_vec"}, int_vec, ev);
        chk({tag, ".clr"}, 32'(clr), 32'(e_clr));
        chk({tag, ".clr_int"}, 32'(clr_int), 32'(e_clri));
        chk({tag, ".isr"}, 32'(isr), 32'(e_isr));
        chk({tag, ".depth"}, 32'(nest_depth), 32'($countones(e_isr)));
    endtask

    task automatic drive(input logic [2:0] i_ir, input logic i_ie, input logic i_take,
                         input logic i_eret);
        ir = i_ir; ie = i_ie; take = i_take; eret = i_eret;
    endtask

    initial begin
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        chk_all("reset", 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        rst_n = 1'b1;
        #3;

        //   ir      take  eret  req   id    clr   clr_int isr
        // single line, take on first request cycle
        add(3'b001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 3'b000);
        add(3'b001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 3'b001);
        add(3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b001);
        add(3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        // two lines together: highest wins, lower masked until eret
        add(3'b101, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 3'b000, 3'b000);
        add(3'b101, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 3'b100, 3'b100);
        add(3'b001, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 3'b000, 3'b100);
        add(3'b001, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 3'b000, 3'b100);
        add(3'b001, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3'b000, 3'b000);
        add(3'b001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 3'b000);
        add(3'b001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 3'b001);
        add(3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b001);
        // nesting: line 1 preempts line 0 in service
        add(3'b010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 3'b000, 3'b001);
        add(3'b010, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 3'b010, 3'b011);
        add(3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'b000, 3'b011);
        add(3'b000, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'b000, 3'b001);
        add(3'b000, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'b000, 3'b000);
        // take without a request is ignored
        add(3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'b000, 3'b000);
        // full nesting to depth 3, then unwind (last eret on empty isr ignored)
        add(3'b001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 3'b000);
        add(3'b001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 3'b001);
        add(3'b010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b001);
        add(3'b010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 3'b000, 3'b001);
        add(3'b010, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 3'b010, 3'b011);
        add(3'b100, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'b000, 3'b011);
        add(3'b100, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 3'b000, 3'b011);
        add(3'b100, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 3'b100, 3'b111);
        add(3'b000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 3'b000, 3'b111);
        add(3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3'b000, 3'b011);
        add(3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3'b000, 3'b001);
        add(3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3'b000, 3'b000);
        add(3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3'b000, 3'b000);

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].ir, tbl[k].ie, tbl[k].take, tbl[k].eret);
            tick();
            chk_all($sformatf("vec%0d", k), tbl[k].e_req, tbl[k].e_id, tbl[k].e_clr,
                    tbl[k].e_clri, tbl[k].e_isr);
        end

        // ie dropped while requesting: request withdrawn, no clear strobe
        drive(3'b010, 1'b1, 1'b0, 1'b0); tick();
        chk_all("drop.req", 1'b1, 2'd1, 1'b0, 3'b000, 3'b000);
        drive(3'b010, 1'b0, 1'b0, 1'b0); tick();
        chk_all("drop.idle", 1'b0, 2'd1, 1'b0, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("drop.hold%0d", k), 1'b0, 2'd1, 1'b0, 3'b000, 3'b000);
        end

        // higher line arrives while requesting: int_id upgrades before take
        drive(3'b001, 1'b1, 1'b0, 1'b0); tick();
        chk_all("upg.req0", 1'b1, 2'd0, 1'b0, 3'b000, 3'b000);
        drive(3'b101, 1'b1, 1'b0, 1'b0); tick();
        chk_all("upg.req2", 1'b1, 2'd2, 1'b0, 3'b000, 3'b000);
        drive(3'b101, 1'b1, 1'b1, 1'b0); tick();
        chk_all("upg.ack", 1'b0, 2'd2, 1'b1, 3'b100, 3'b100);
        drive(3'b001, 1'b1, 1'b0, 1'b0); tick();
        chk_all("upg.idle", 1'b0, 2'd2, 1'b0, 3'b000, 3'b100);
        drive(3'b001, 1'b1, 1'b0, 1'b1); tick();
        chk_all("upg.eret", 1'b0, 2'd2, 1'b0, 3'b000, 3'b000);
        drive(3'b000, 1'b1, 1'b0, 1'b0); tick();
        chk_all("upg.quiet", 1'b0, 2'd2, 1'b0, 3'b000, 3'b000);

        // eret and take in the same cycle, then reset while in S_ACK
        drive(3'b001, 1'b1, 1'b0, 1'b0); tick();
        drive(3'b001, 1'b1, 1'b1, 1'b0); tick();
        chk_all("col.isr0", 1'b0, 2'd0, 1'b1, 3'b001, 3'b001);
        drive(3'b000, 1'b1, 1'b0, 1'b0); tick();
        drive(3'b010, 1'b1, 1'b0, 1'b0); tick();
        chk_all("col.req1", 1'b1, 2'd1, 1'b0, 3'b000, 3'b001);
        drive(3'b010, 1'b1, 1'b1, 1'b1); tick();
        chk_all("col.ack", 1'b0, 2'd1, 1'b1, 3'b010, 3'b010);
        drive(3'b010, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rst.ack", 1'b0, 2'd0, 1'b0, 3'b000, 3'b000);
        #3 rst_n = 1'b1;
        tick();
        chk_all("rst.rereq", 1'b1, 2'd1, 1'b0, 3'b000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
